// File: rtl/diff_accum_if.sv
// Handshake bundle between the SUB stage, the block accumulator and its consumer.
// The master drives samples in and consumes sums; the slave is the accumulator.
interface diff_accum_if #(
    parameter int unsigned DATAWIDTH = 16
);
    logic [DATAWIDTH-1:0] diff;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] sum;
    logic                 sat;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output diff, in_valid, out_ready,
        input  in_ready, sum, sat, out_valid
    );

    modport slave (
        input  diff, in_valid, out_ready,
        output in_ready, sum, sat, out_valid
    );
endinterface

// File: rtl/diff_accum.sv
// Sums COUNT signed difference samples with saturation and presents each block sum
// through a valid/ready handshake; it stalls input while a result is pending.
module diff_accum #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned COUNT     = 4
) (
    input logic        clk,
    input logic        rst_n,
    diff_accum_if.slave bus
);
    localparam int unsigned CW = $clog2(COUNT + 1);
    localparam logic [DATAWIDTH-1:0] MAXV = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic [DATAWIDTH-1:0] MINV = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [CW-1:0]        LAST = CW'(COUNT - 1);

    typedef enum logic {StAccum, StHold} state_e;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic [DATAWIDTH-1:0] sum_q, sum_d;
    logic                 sat_acc_q, sat_acc_d;
    logic                 sat_q, sat_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH:0]   wide;
    logic [DATAWIDTH-1:0] clamped;
    logic                 ovf;

    // One extra bit of headroom; overflow shows as the top two bits disagreeing.
    assign wide    = {acc_q[DATAWIDTH-1], acc_q} + {bus.diff[DATAWIDTH-1], bus.diff};
    assign ovf     = wide[DATAWIDTH] ^ wide[DATAWIDTH-1];
    assign clamped = ovf ? (wide[DATAWIDTH] ? MINV : MAXV) : wide[DATAWIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sat_acc_d = sat_acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sat_d     = sat_q;
        case (state_q)
            StAccum: begin
                if (bus.in_valid) begin
                    if (cnt_q == LAST) begin
                        sum_d     = clamped;
                        sat_d     = sat_acc_q | ovf;
                        acc_d     = '0;
                        sat_acc_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = StHold;
                    end else begin
                        acc_d     = clamped;
                        sat_acc_d = sat_acc_q | ovf;
                        cnt_d     = cnt_q + CW'(1);
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StAccum;
            acc_q     <= '0;
            sat_acc_q <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sat_acc_q <= sat_acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.in_ready  = (state_q == StAccum);
    assign bus.out_valid = (state_q == StHold);
    assign bus.sum       = sum_q;
    assign bus.sat       = sat_q;
endmodule
